// File: rtl/dac_spi_tx_if.sv
// rtl/dac_spi_tx_if.sv - Start/word handshake and DAC SPI pin bundle for dac_spi_tx
interface dac_spi_tx_if #(
   parameter int FRAME_BITS = 24
);
   logic                  start;
   logic [FRAME_BITS-1:0] word;
   logic                  busy;
   logic                  done;
   logic                  dac_cs_n;
   logic                  dac_sclk;
   logic                  dac_mosi;

   modport master (
      output start, word,
      input  busy, done, dac_cs_n, dac_sclk, dac_mosi
   );

   modport slave (
      input  start, word,
      output busy, done, dac_cs_n, dac_sclk, dac_mosi
   );
endinterface

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - Mode-0 SPI serialiser for the 24-bit DAC command word
// One chip-select framed, MSB-first frame per accepted start, followed by a fixed cs_n-high gap.
module dac_spi_tx #(
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = 4,
   parameter int FRAME_BITS = 24
) (
   input logic         clk,
   input logic         rst,
   dac_spi_tx_if.slave bus
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   state_t                state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  cs_n_q, cs_n_d;
   logic                  sclk_q, sclk_d;
   logic                  mosi_q, mosi_d;
   logic                  div_end;
   logic                  accept;

   assign div_end = (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      div_d   = div_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      accept  = 1'b0;

      case (state_q)
         IDLE: begin
            accept = bus.start;
         end
         SHIFT: begin
            div_d = div_q + 1'b1;
            if (div_end) begin
               div_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else if (bit_q == BIT_LAST) begin
                  sclk_d  = 1'b0;
                  state_d = HOLD;
               end else begin
                  // Next bit is presented only on the falling SCLK edge.
                  sclk_d  = 1'b0;
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q << 1;
                  mosi_d  = shift_q[FRAME_BITS-2];
               end
            end
         end
         HOLD: begin
            div_d = div_q + 1'b1;
            if (div_end) begin
               div_d   = '0;
               cs_n_d  = 1'b1;
               done_d  = 1'b1;
               mosi_d  = 1'b0;
               gap_d   = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
               // A start held high reuses this edge so frames run back-to-back.
               accept  = bus.start;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         state_d = SHIFT;
         shift_d = bus.word;
         mosi_d  = bus.word[FRAME_BITS-1];
         cs_n_d  = 1'b0;
         sclk_d  = 1'b0;
         busy_d  = 1'b1;
         div_d   = '0;
         bit_d   = '0;
         gap_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.dac_cs_n = cs_n_q;
   assign bus.dac_sclk = sclk_q;
   assign bus.dac_mosi = mosi_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - Scoreboard bench for dac_spi_tx (CLK_DIV=2/GAP=4 and CLK_DIV=1/GAP=1)
module tb_dac_spi_tx;
   localparam int FB = 24;

   typedef struct {
      int            dut;
      logic [FB-1:0] word;
      int            gap;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   int   nframes[2];
   bit   stray_done[2];
   bit   sclk_outside[2];
   bit   mosi_moved[2];

   logic          start_v[2];
   logic [FB-1:0] word_v[2];
   logic          busy_v[2];
   logic          done_v[2];
   logic          cs_n_v[2];
   logic          sclk_v[2];
   logic          mosi_v[2];

   dac_spi_tx_if #(.FRAME_BITS(FB)) bus [2] ();

   dac_spi_tx #(.CLK_DIV(2), .GAP_CYCLES(4), .FRAME_BITS(FB)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus[0])
   );

   dac_spi_tx #(.CLK_DIV(1), .GAP_CYCLES(1), .FRAME_BITS(FB)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_mon
      localparam int D     = (g == 0) ? 2 : 1;
      localparam int G     = (g == 0) ? 4 : 1;
      localparam int RISE  = (2 * FB + 1) * D;
      localparam int BUSYF = RISE + G;

      assign bus[g].start = start_v[g];
      assign bus[g].word  = word_v[g];
      assign busy_v[g]    = bus[g].busy;
      assign done_v[g]    = bus[g].done;
      assign cs_n_v[g]    = bus[g].dac_cs_n;
      assign sclk_v[g]    = bus[g].dac_sclk;
      assign mosi_v[g]    = bus[g].dac_mosi;

      logic          pcs   = 1'b1;
      logic          psclk = 1'b0;
      logic          pmosi = 1'b0;
      logic          pbusy = 1'b0;
      logic [FB-1:0] cap   = '0;
      int            nbits = 0;
      int            e0    = 0;
      int            rise_cyc = 0;
      bit            in_frame = 0;
      exp_t          e;

      always @(negedge clk) begin
         if (rst) begin
            in_frame = 0;
            cap      = '0;
            nbits    = 0;
            if (done_v[g] !== 1'b0) stray_done[g] = 1;
         end else begin
            if (pcs && !cs_n_v[g]) begin
               if (exp_q.size() > 0 && exp_q[0].dut == g && exp_q[0].gap > 0)
                  check("cs_gap_cycles", cyc - rise_cyc, exp_q[0].gap);
               e0       = cyc;
               in_frame = 1;
               cap      = '0;
               nbits    = 0;
            end
            if (!psclk && sclk_v[g]) begin
               if (cs_n_v[g]) sclk_outside[g] = 1;
               else begin
                  cap = {cap[FB-2:0], mosi_v[g]};
                  nbits++;
               end
            end
            if (psclk && sclk_v[g] && mosi_v[g] !== pmosi) mosi_moved[g] = 1;
            if (done_v[g] && !(!pcs && cs_n_v[g])) stray_done[g] = 1;
            if (!pcs && cs_n_v[g] && in_frame) begin
               in_frame = 0;
               rise_cyc = cyc;
               nframes[g]++;
               check("cs_rise_time", cyc - e0, RISE);
               check("done_at_rise", done_v[g], 1);
               check("sclk_rise_count", nbits, FB);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: dut %0d got frame %0h expected none", g, cap);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_dut", g, e.dut);
                  check("frame_data", cap, e.word);
               end
            end
            if (pbusy && !busy_v[g]) check("busy_fall_time", cyc - e0, BUSYF);
         end
         pcs   = cs_n_v[g];
         psclk = sclk_v[g];
         pmosi = mosi_v[g];
         pbusy = busy_v[g];
      end
   end

   task automatic push_exp(input int g, input logic [FB-1:0] w, input int gap);
      exp_t e;
      e.dut  = g;
      e.word = w;
      e.gap  = gap;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start(input int g, input logic [FB-1:0] w);
      @(posedge clk); #1;
      start_v[g] = 1'b1;
      word_v[g]  = w;
      @(posedge clk); #1;
      start_v[g] = 1'b0;
   endtask

   task automatic wait_idle(input int g, input string name);
      int n = 0;
      while (busy_v[g] !== 1'b0 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy_v[g] !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL %s: busy=%b after 400 cycles, expected 0", name, busy_v[g]);
      end
   endtask

   task automatic wait_done(input int g);
      int n = 0;
      while (done_v[g] !== 1'b1 && n < 150) begin
         @(posedge clk); #1;
         n++;
      end
      if (done_v[g] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_done: done=%b after 150 cycles, expected 1", done_v[g]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation time %0t exceeded, expected completion", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int f0;
      start_v[0] = 1'b0; start_v[1] = 1'b0;
      word_v[0]  = '0;   word_v[1]  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs_n_a", cs_n_v[0], 1);
      check("rst_sclk_a", sclk_v[0], 0);
      check("rst_mosi_a", mosi_v[0], 0);
      check("rst_busy_a", busy_v[0], 0);
      check("rst_done_a", done_v[0], 0);
      check("rst_cs_n_b", cs_n_v[1], 1);
      check("rst_busy_b", busy_v[1], 0);
      rst = 1'b0;

      push_exp(0, 24'h3FA5C0, 0);
      pulse_start(0, 24'h3FA5C0);
      wait_idle(0, "idle_single");

      push_exp(0, 24'h3FA5C0, 0);
      pulse_start(0, 24'h3FA5C0);
      repeat (9) @(posedge clk);
      #1 word_v[0] = 24'h000000;
      wait_idle(0, "idle_word_change");

      f0 = nframes[0];
      push_exp(0, 24'h3FA5C0, 0);
      word_v[0] = 24'h3FA5C0;
      pulse_start(0, 24'h3FA5C0);
      repeat (48) @(posedge clk);
      #1 start_v[0] = 1'b1;
      @(posedge clk); #1 start_v[0] = 1'b0;
      wait_done(0);
      start_v[0] = 1'b1;
      @(posedge clk); #1 start_v[0] = 1'b0;
      wait_idle(0, "idle_ignored_start");
      repeat (10) @(posedge clk);
      #1;
      check("ignored_start_frames", nframes[0] - f0, 1);
      check("ignored_start_busy", busy_v[0], 0);

      f0 = nframes[0];
      push_exp(0, 24'h3FF000, 0);
      push_exp(0, 24'h3F0FF0, 4);
      @(posedge clk); #1;
      start_v[0] = 1'b1;
      word_v[0]  = 24'h3FF000;
      @(posedge clk); #1;
      word_v[0]  = 24'h3F0FF0;
      repeat (110) @(posedge clk);
      #1 start_v[0] = 1'b0;
      wait_idle(0, "idle_back_to_back");
      repeat (3) @(posedge clk);
      check("back_to_back_frames", nframes[0] - f0, 2);

      f0 = nframes[0];
      pulse_start(0, 24'hABCDEF);
      repeat (20) @(posedge clk);
      check("pre_reset_cs_low", cs_n_v[0], 0);
      #1 rst = 1'b1;
      #1;
      check("midrst_cs_n", cs_n_v[0], 1);
      check("midrst_sclk", sclk_v[0], 0);
      check("midrst_mosi", mosi_v[0], 0);
      check("midrst_busy", busy_v[0], 0);
      check("midrst_done", done_v[0], 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("aborted_frame_count", nframes[0] - f0, 0);
      check("post_reset_busy", busy_v[0], 0);

      push_exp(1, 24'hC35A96, 0);
      pulse_start(1, 24'hC35A96);
      wait_idle(1, "idle_fast");
      repeat (3) @(posedge clk);

      for (int g = 0; g < 2; g++) begin
         check("stray_done", stray_done[g], 0);
         check("sclk_outside_cs", sclk_outside[g], 0);
         check("mosi_moved_sclk_high", mosi_moved[g], 0);
      end
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
